rvfi_commit_monitor: RTL and testbench
======================================

// Module: rvfi_commit_monitor
// PURPOSE
//  Parametrised retirement monitor for the mp4 bench. Takes up to NUM_LANES in-order commits per
//  cycle and produces per-lane rvfi order numbers, a sticky halt flag and a sticky watchdog timeout.
//  Replaces the single-lane combinational halt equation in the bench top. Halt requires repeated
//  self-loop commits plus a drained pipe. Sits between the datapath commit taps and rvfi_itf.
// PARAMETERS
//  NUM_LANES        1        commit lanes per cycle (1..4)
//  XLEN             32       PC width
//  ORDER_W          64       rvfi order counter width
//  HALT_REPEAT      2        consecutive self-loop commits needed to declare halt (>=1)
//  WATCHDOG_CYCLES  100000   commit-free cycles before timeout (>=1)
// PORTS
//  clk            in   1               clock
//  rst            in   1               asynchronous reset, active-high
//  commit_valid   in   NUM_LANES       lane i retires an instruction this cycle
//  commit_pc      in   NUM_LANES*XLEN  lane i pc_rdata (lane i at [i*XLEN +: XLEN])
//  commit_pc_next in   NUM_LANES*XLEN  lane i pc_wdata
//  pipe_drained   in   1               all stages behind the commit point hold nops
//  out_valid      out  NUM_LANES       registered copy of commit_valid
//  out_order      out  NUM_LANES*ORDER_W  rvfi order of each out lane
//  total_commits  out  ORDER_W         running retired count (== next order to assign)
//  halt           out  1               sticky: program reached terminal loop
//  halt_pc        out  XLEN            PC of the self-loop instruction that caused halt
//  timeout        out  1               sticky: no commit for WATCHDOG_CYCLES cycles
//  protocol_err   out  1               sticky: non-contiguous commit_valid observed
// BEHAVIOUR
//  - Reset: all outputs 0; order counter, repeat counter and idle counter cleared. Async assert,
//    outputs valid 0 in the same cycle reset asserts.
//  - Latency: out_valid/out_order appear 1 cycle after the commit inputs. No back-pressure.
//  - Order: lane i gets order_cnt + popcount(commit_valid[i-1:0]); order_cnt += popcount(valid).
//    Arithmetic is modulo 2^ORDER_W (wraps, no flag). total_commits = order_cnt (registered).
//  - Contiguity: valid lanes must be a prefix from lane 0 (e.g. 4'b0011 ok, 4'b0101 not).
//    Violation sets protocol_err; orders are still assigned by popcount (same formula).
//  - Self-loop: lane is self-loop when valid && commit_pc_next == commit_pc.
//    Examined lane = highest valid lane. If it is self-loop and all lower valid lanes are also
//    self-loops with the same pc: rep_cnt += 1 (saturates at HALT_REPEAT). Any other commit
//    cycle: rep_cnt = that lane's self-loop ? 1 : 0. Cycles with no commit: rep_cnt held.
//  - Halt: state RUN -> HALTED on the clock edge where rep_cnt (after update) >= HALT_REPEAT and
//    pipe_drained == 1 that cycle. Evaluated only in cycles with at least one commit.
//    If pipe_drained == 0, stay RUN and re-evaluate on the next commit cycle.
//    halt_pc captured on that edge. HALTED is absorbing until reset.
//    Commits after halt still get orders (monitor keeps counting).
//  - Watchdog: idle_cnt clears on any commit cycle and increments otherwise, in RUN only.
//    When idle_cnt reaches WATCHDOG_CYCLES, timeout = 1 (sticky); idle_cnt saturates.
//    In HALTED the counter is frozen, so timeout can't newly assert.
//  - Simultaneous: halt and timeout evaluated independently on the same edge; a commit cycle
//    that also halts still clears idle_cnt.
//  - Reset mid-operation: all state lost; order restarts at 0.
// TESTING
//  1. NUM_LANES=1, 5 single commits pc 0x60..0x70 -> out_order 0..4 one cycle later; total=5.
//  2. NUM_LANES=4, valid=4'b0111 then 4'b1111 -> orders {0,1,2}, then {3,4,5,6}; total=7.
//  3. Self-loop pc 0x80, pc_next 0x80, HALT_REPEAT=2, drained=1 on 2nd commit
//     -> halt=1 after 2nd edge; halt_pc=0x80.
//  4. Same as 3 with drained=0 on 2nd, 1 on 3rd self-loop -> halt on 3rd;
//     a non-loop commit between them resets rep_cnt, so no halt.
//  5. WATCHDOG_CYCLES=10, no commits for 10 cycles -> timeout on 10th; a commit at cycle 9
//     prevents it.
//  6. valid=4'b0101 -> protocol_err=1 sticky; async rst mid-run -> all outputs 0 immediately,
//     next commit gets order 0.

Source files
------------

// File: rtl/rvfi_commit_monitor.sv
// -----------------------------------------------------------------------------
// rvfi_commit_monitor
//
// Retirement monitor for the mp4 bench. It accepts up to NUM_LANES in-order
// commits per cycle and produces per-lane rvfi order numbers, a sticky halt
// flag (terminal self-loop reached with an empty pipe), a sticky commit
// watchdog timeout and a sticky lane-contiguity protocol error.
//
// Ports
//   clk               clock
//   rst               asynchronous reset, active-high
//   i_commit_valid    lane i retires an instruction this cycle
//   i_commit_pc       lane i pc_rdata, lane i at [i*XLEN +: XLEN]
//   i_commit_pc_next  lane i pc_wdata
//   i_pipe_drained    all stages behind the commit point hold nops
//   o_out_valid       registered copy of i_commit_valid
//   o_out_order       rvfi order of each output lane
//   o_total_commits   running retired count (next order to assign)
//   o_halt            sticky: program reached its terminal loop
//   o_halt_pc         pc of the self-loop instruction that caused halt
//   o_timeout         sticky: no commit for WATCHDOG_CYCLES cycles
//   o_protocol_err    sticky: non-contiguous i_commit_valid observed
// -----------------------------------------------------------------------------
module rvfi_commit_monitor #(
    parameter int NUM_LANES       = 1,
    parameter int XLEN            = 32,
    parameter int ORDER_W         = 64,
    parameter int HALT_REPEAT     = 2,
    parameter int WATCHDOG_CYCLES = 100000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LANES-1:0]         i_commit_valid,
    input  logic [NUM_LANES*XLEN-1:0]    i_commit_pc,
    input  logic [NUM_LANES*XLEN-1:0]    i_commit_pc_next,
    input  logic                         i_pipe_drained,
    output logic [NUM_LANES-1:0]         o_out_valid,
    output logic [NUM_LANES*ORDER_W-1:0] o_out_order,
    output logic [ORDER_W-1:0]           o_total_commits,
    output logic                         o_halt,
    output logic [XLEN-1:0]              o_halt_pc,
    output logic                         o_timeout,
    output logic                         o_protocol_err
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = $clog2(NUM_LANES + 1);
    localparam int REP_W  = $clog2(HALT_REPEAT + 1);
    localparam int IDLE_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(HALT_REPEAT);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(WATCHDOG_CYCLES);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t                      r_state;
    logic [ORDER_W-1:0]          r_order_cnt;
    logic [REP_W-1:0]            r_rep_cnt;
    logic [IDLE_W-1:0]           r_idle_cnt;
    logic [NUM_LANES-1:0]        r_out_valid;
    logic [NUM_LANES*ORDER_W-1:0] r_out_order;
    logic [XLEN-1:0]             r_halt_pc;
    logic                        r_timeout;
    logic                        r_protocol_err;

    state_t                      w_state_next;
    logic                        w_any;
    logic                        w_contig;
    logic [CNT_W-1:0]            w_pop;
    logic [CNT_W-1:0]            w_prefix [NUM_LANES];
    logic [NUM_LANES-1:0]        w_lane_loop;
    logic [LANE_W-1:0]           w_hi_idx;
    logic [XLEN-1:0]             w_hi_pc;
    logic                        w_hi_loop;
    logic                        w_all_loop;
    logic [REP_W-1:0]            w_rep_next;
    logic [IDLE_W-1:0]           w_idle_next;
    logic                        w_halt_fire;
    logic [NUM_LANES:0]          w_valid_ext;

    assign w_any       = |i_commit_valid;
    assign w_valid_ext = {1'b0, i_commit_valid};
    // A legal valid vector is 2^k-1: adding one must clear every set bit.
    assign w_contig    = ((w_valid_ext & (w_valid_ext + 1'b1)) == '0);

    // Lane decode: prefix popcounts, per-lane self-loop, highest valid lane.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_pop       = '0;
        w_hi_idx    = '0;
        w_lane_loop = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_prefix[i]    = w_pop;
            w_lane_loop[i] = i_commit_valid[i] &&
                             (i_commit_pc_next[i*XLEN +: XLEN] == i_commit_pc[i*XLEN +: XLEN]);
            if (i_commit_valid[i]) begin
                w_pop    = w_pop + CNT_W'(1);
                w_hi_idx = LANE_W'(i);
            end
        end
        w_hi_pc    = i_commit_pc[w_hi_idx*XLEN +: XLEN];
        w_hi_loop  = w_lane_loop[w_hi_idx];
        w_all_loop = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (i_commit_valid[i] && (LANE_W'(i) < w_hi_idx) &&
                !(w_lane_loop[i] && (i_commit_pc[i*XLEN +: XLEN] == w_hi_pc)))
                w_all_loop = 1'b0;
        end
    end

    // Next-state: repeat counter, halt FSM, watchdog.
    always_comb begin
        w_rep_next   = r_rep_cnt;
        w_idle_next  = r_idle_cnt;
        w_state_next = r_state;
        w_halt_fire  = 1'b0;

        if (w_any) begin
            if (w_hi_loop && w_all_loop)
                w_rep_next = (r_rep_cnt < REP_MAX) ? r_rep_cnt + REP_W'(1) : r_rep_cnt;
            else
                w_rep_next = w_hi_loop ? REP_W'(1) : '0;
        end

        case (r_state)
            ST_RUN: begin
                if (w_any && (w_rep_next >= REP_MAX) && i_pipe_drained) begin
                    w_state_next = ST_HALTED;
                    w_halt_fire  = 1'b1;
                end
                if (w_any)
                    w_idle_next = '0;
                else if (r_idle_cnt < IDLE_MAX)
                    w_idle_next = r_idle_cnt + IDLE_W'(1);
            end
            default: ;  // halted: watchdog frozen, state absorbing
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_order_cnt    <= '0;
            r_rep_cnt      <= '0;
            r_idle_cnt     <= '0;
            r_out_valid    <= '0;
            r_out_order    <= '0;
            r_halt_pc      <= '0;
            r_timeout      <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            r_state     <= w_state_next;
            r_order_cnt <= r_order_cnt + ORDER_W'(w_pop);
            r_rep_cnt   <= w_rep_next;
            r_idle_cnt  <= w_idle_next;
            r_out_valid <= i_commit_valid;
            for (int i = 0; i < NUM_LANES; i++)
                r_out_order[i*ORDER_W +: ORDER_W] <= r_order_cnt + ORDER_W'(w_prefix[i]);
            if (w_halt_fire)
                r_halt_pc <= w_hi_pc;
            if (w_idle_next == IDLE_MAX)
                r_timeout <= 1'b1;
            if (w_any && !w_contig)
                r_protocol_err <= 1'b1;
        end
    end

    assign o_out_valid     = r_out_valid;
    assign o_out_order     = r_out_order;
    assign o_total_commits = r_order_cnt;
    assign o_halt          = (r_state == ST_HALTED);
    assign o_halt_pc       = r_halt_pc;
    assign o_timeout       = r_timeout;
    assign o_protocol_err  = r_protocol_err;

endmodule

// File: tb/tb_rvfi_commit_monitor.sv
// -----------------------------------------------------------------------------
// tb_rvfi_commit_monitor
//
// Bench for rvfi_commit_monitor with 4 lanes, 8-bit order counter, halt after
// 2 self-loop commit cycles and a 10-cycle watchdog. Stimulus pushes expected
// per-lane orders into a queue; a negedge monitor pops and compares whenever
// the DUT presents a valid output. Sticky flags are checked inline.
// -----------------------------------------------------------------------------
module tb_rvfi_commit_monitor;

    localparam int NL  = 4;
    localparam int XL  = 32;
    localparam int OW  = 8;

    typedef struct packed {
        logic [NL-1:0]         v;
        logic [NL-1:0][OW-1:0] ord;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NL-1:0]      commit_valid = '0;
    logic [NL*XL-1:0]   commit_pc = '0;
    logic [NL*XL-1:0]   commit_pc_next = '0;
    logic               pipe_drained = 1'b0;
    logic [NL-1:0]      out_valid;
    logic [NL*OW-1:0]   out_order;
    logic [OW-1:0]      total_commits;
    logic               halt;
    logic [XL-1:0]      halt_pc;
    logic               timeout;
    logic               protocol_err;

    exp_t               sb_q[$];
    logic [OW-1:0]      m_order = '0;
    int                 n_pass  = 0;
    int                 n_total = 0;

    rvfi_commit_monitor #(
        .NUM_LANES(NL), .XLEN(XL), .ORDER_W(OW),
        .HALT_REPEAT(2), .WATCHDOG_CYCLES(10)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_commit_valid  (commit_valid),
        .i_commit_pc     (commit_pc),
        .i_commit_pc_next(commit_pc_next),
        .i_pipe_drained  (pipe_drained),
        .o_out_valid     (out_valid),
        .o_out_order     (out_order),
        .o_total_commits (total_commits),
        .o_halt          (halt),
        .o_halt_pc       (halt_pc),
        .o_timeout       (timeout),
        .o_protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare every valid output beat against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid != '0) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got valid 0x%0h expected no output", out_valid);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_valid", 64'(out_valid), 64'(e.v));
                for (int i = 0; i < NL; i++)
                    if (e.v[i])
                        check($sformatf("out_order[%0d]", i),
                              64'(out_order[i*OW +: OW]), 64'(e.ord[i]));
            end
        end
    end

    // One commit cycle. loop=1: every lane is a self-loop at pc.
    // loop=0: lane i at pc+4i falling through to pc+4i+4.
    task automatic step(input logic [NL-1:0] v, input logic [XL-1:0] pc,
                        input bit loop, input bit drained);
        exp_t e;
        logic [OW-1:0] cnt;
        for (int i = 0; i < NL; i++) begin
            commit_pc[i*XL +: XL]      = loop ? pc : pc + XL'(4*i);
            commit_pc_next[i*XL +: XL] = loop ? pc : pc + XL'(4*i + 4);
        end
        commit_valid = v;
        pipe_drained = drained;
        if (v != '0) begin
            cnt = '0;
            e.v = v;
            for (int i = 0; i < NL; i++) begin
                e.ord[i] = m_order + cnt;
                if (v[i]) cnt = cnt + 1'b1;
            end
            m_order = m_order + cnt;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        commit_valid = '0;
        pipe_drained = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        m_order = '0;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_total", 64'(total_commits), 0);
        check("rst_flags", {halt, timeout, protocol_err}, 0);
        do_reset();

        // Five single-lane commits, pc 0x60..0x70.
        for (int k = 0; k < 5; k++) step(4'b0001, 32'h60 + 32'(4*k), 1'b0, 1'b1);
        check("t1_total", 64'(total_commits), 5);
        check("t1_no_halt", 64'(halt), 0);

        // Multi-lane: {0,1,2} then {3,4,5,6}.
        do_reset();
        step(4'b0111, 32'h100, 1'b0, 1'b1);
        step(4'b1111, 32'h10c, 1'b0, 1'b1);
        check("t2_total", 64'(total_commits), 7);
        check("t2_perr", 64'(protocol_err), 0);

        // Watchdog: 9 idle then commit keeps it quiet; 10 idle trips it.
        do_reset();
        step(4'b0001, 32'h200, 1'b0, 1'b1);
        idle(9);
        check("wd_9_idle", 64'(timeout), 0);
        step(4'b0001, 32'h204, 1'b0, 1'b1);
        idle(9);
        check("wd_rearm", 64'(timeout), 0);
        idle(1);
        check("wd_10_idle", 64'(timeout), 1);

        // Self-loop halt on the 2nd drained loop commit.
        do_reset();
        step(4'b0001, 32'h80, 1'b1, 1'b1);
        check("t3_first", 64'(halt), 0);
        step(4'b0001, 32'h80, 1'b1, 1'b1);
        check("t3_halt", 64'(halt), 1);
        check("t3_halt_pc", 64'(halt_pc), 64'h80);
        step(4'b0011, 32'h300, 1'b0, 1'b1);   // orders 2,3 after halt
        check("t3_total", 64'(total_commits), 4);
        idle(12);
        check("t3_wd_frozen", 64'(timeout), 0);
        check("t3_halt_sticky", 64'(halt), 1);

        // Halt deferred by an undrained pipe.
        do_reset();
        step(4'b0001, 32'h80, 1'b1, 1'b0);
        step(4'b0001, 32'h80, 1'b1, 1'b0);
        check("t4_undrained", 64'(halt), 0);
        step(4'b0001, 32'h80, 1'b1, 1'b1);
        check("t4_halt3", 64'(halt), 1);
        check("t4_halt_pc", 64'(halt_pc), 64'h80);

        // A fall-through commit between loops resets the repeat count.
        do_reset();
        step(4'b0001, 32'h90, 1'b1, 1'b1);
        step(4'b0001, 32'h94, 1'b0, 1'b1);
        step(4'b0001, 32'h90, 1'b1, 1'b1);
        check("t4b_broken", 64'(halt), 0);
        step(4'b0001, 32'h90, 1'b1, 1'b1);
        check("t4b_halt", 64'(halt), 1);

        // Two loop lanes in one cycle count as a single repeat.
        do_reset();
        step(4'b0011, 32'hA0, 1'b1, 1'b1);
        check("ml_one_rep", 64'(halt), 0);
        step(4'b0001, 32'hA0, 1'b1, 1'b1);
        check("ml_halt", 64'(halt), 1);
        check("ml_halt_pc", 64'(halt_pc), 64'hA0);

        // Order wrap at 2^8.
        do_reset();
        for (int k = 0; k < 64; k++) step(4'b1111, 32'h400, 1'b0, 1'b1);
        check("wrap_total", 64'(total_commits), 0);
        step(4'b0001, 32'h400, 1'b0, 1'b1);   // order 0 again

        // Non-contiguous lanes, then async reset mid-run.
        do_reset();
        step(4'b0101, 32'h500, 1'b0, 1'b1);   // lane0=0, lane2=1
        check("perr_set", 64'(protocol_err), 1);
        step(4'b0001, 32'h510, 1'b0, 1'b1);
        check("perr_sticky", 64'(protocol_err), 1);
        step(4'b1111, 32'h520, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 0);
        check("arst_total", 64'(total_commits), 0);
        check("arst_flags", {halt, timeout, protocol_err}, 0);
        sb_q.delete();
        m_order = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(4'b0001, 32'h600, 1'b0, 1'b1);   // order restarts at 0
        check("arst_total_after", 64'(total_commits), 1);

        idle(2);
        check("sb_drained", 64'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
